// File: rtl/dmem_responder_if.sv
// Processor data-memory port: byte address, lane-aligned store data, lane mask,
// store strobe and combinational load data.
interface dmem_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  wmask;
  logic        wen;
  logic [31:0] read_data;

  modport master (output address, write_data, wmask, wen, input read_data);
  modport slave  (input address, write_data, wmask, wen, output read_data);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-maskable word RAM plus an MMIO page with a 64-bit
// machine timer, a console TX FIFO and a tohost halt register.
module dmem_responder #(
  parameter int          RAM_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready,
  output logic               timer_irq,
  output logic               halt,
  output logic [31:0]        exit_code
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [3:0] OFF_CON_TX   = 4'h0;
  localparam logic [3:0] OFF_CON_STAT = 4'h1;
  localparam logic [3:0] OFF_MTIME_LO = 4'h2;
  localparam logic [3:0] OFF_MTIME_HI = 4'h3;
  localparam logic [3:0] OFF_CMP_LO   = 4'h4;
  localparam logic [3:0] OFF_CMP_HI   = 4'h5;
  localparam logic [3:0] OFF_TOHOST   = 4'h6;

  logic          store, ram_sel, mmio_sel, mmio_st;
  logic [3:0]    off;
  logic [AW-1:0] word_idx;
  logic          unused_addr_lsbs;

  assign store            = bus.wen && (bus.wmask != 4'b0);
  assign ram_sel          = (bus.address[31:AW+2] == '0);
  assign mmio_sel         = (bus.address[31:6] == MMIO_BASE[31:6]);
  assign mmio_st          = store && mmio_sel;
  assign off              = bus.address[5:2];
  assign word_idx         = bus.address[AW+1:2];
  assign unused_addr_lsbs = ^bus.address[1:0];

  // Word RAM, byte-lane writable, not reset
  logic [3:0][7:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset && store && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wmask[i]) ram[word_idx][i] <= bus.write_data[8*i +: 8];
      end
    end
  end

  // Machine timer: each of the 8 bytes is independently writable through LO/HI
  logic [63:0] mtime_reg, mtime_next, mtime_wr;
  logic [63:0] mtimecmp_reg, mtimecmp_next;
  logic [7:0]  mtime_lane_we, cmp_lane_we;
  logic        mtime_hit, timer_irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_timer_lane
      localparam int         LANE    = gi % 4;
      localparam logic [3:0] MT_OFF  = (gi < 4) ? OFF_MTIME_LO : OFF_MTIME_HI;
      localparam logic [3:0] CMP_OFF = (gi < 4) ? OFF_CMP_LO : OFF_CMP_HI;
      assign mtime_lane_we[gi] = mmio_st && (off == MT_OFF) && bus.wmask[LANE];
      assign cmp_lane_we[gi]   = mmio_st && (off == CMP_OFF) && bus.wmask[LANE];
      assign mtime_wr[8*gi +: 8] = mtime_lane_we[gi] ? bus.write_data[8*LANE +: 8]
                                                     : mtime_reg[8*gi +: 8];
      assign mtimecmp_next[8*gi +: 8] = cmp_lane_we[gi] ? bus.write_data[8*LANE +: 8]
                                                        : mtimecmp_reg[8*gi +: 8];
    end
  endgenerate

  // A software write to mtime replaces that cycle's increment
  assign mtime_hit  = mmio_st && ((off == OFF_MTIME_LO) || (off == OFF_MTIME_HI));
  assign mtime_next = mtime_hit ? mtime_wr : mtime_reg + 64'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_reg     <= '0;
      mtimecmp_reg  <= '1;
      timer_irq_reg <= 1'b0;
    end else begin
      mtime_reg     <= mtime_next;
      mtimecmp_reg  <= mtimecmp_next;
      timer_irq_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign timer_irq = timer_irq_reg;

  // Console TX FIFO; full is judged before any same-cycle pop
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic          full, empty, push_req, push, pop, overflow_reg, overflow_clr;

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign push_req     = mmio_st && (off == OFF_CON_TX) && bus.wmask[0];
  assign push         = push_req && !full;
  assign pop          = !empty && con_ready;
  assign overflow_clr = mmio_st && (off == OFF_CON_STAT) && bus.wmask[0] && bus.write_data[2];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wr_ptr_reg] <= bus.write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      if (push_req && full) overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
    end
  end

  assign con_valid = !empty;
  assign con_data  = fifo_mem[rd_ptr_reg];

  // tohost: first store wins, later stores ignored until reset
  logic        halt_reg;
  logic [31:0] exit_code_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_reg      <= 1'b0;
      exit_code_reg <= '0;
    end else if (mmio_st && (off == OFF_TOHOST) && !halt_reg) begin
      halt_reg      <= 1'b1;
      exit_code_reg <= bus.write_data;
    end
  end

  assign halt      = halt_reg;
  assign exit_code = exit_code_reg;

  always_comb begin
    bus.read_data = '0;
    if (ram_sel) begin
      bus.read_data = ram[word_idx];
    end else if (mmio_sel) begin
      case (off)
        OFF_CON_STAT: bus.read_data = {29'b0, overflow_reg, empty, full};
        OFF_MTIME_LO: bus.read_data = mtime_reg[31:0];
        OFF_MTIME_HI: bus.read_data = mtime_reg[63:32];
        OFF_CMP_LO:   bus.read_data = mtimecmp_reg[31:0];
        OFF_CMP_HI:   bus.read_data = mtimecmp_reg[63:32];
        OFF_TOHOST:   bus.read_data = exit_code_reg;
        default:      bus.read_data = '0;
      endcase
    end
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder for the processor's data-memory port: it serves loads and stores issued on address/write_data/wmask/wen and returns read_data. The address space is decoded into a byte-maskable word RAM and an MMIO page. The MMIO page holds a 64-bit machine timer with compare interrupt, a console TX FIFO with valid/ready drain, and a tohost halt register. The block sits beside the processor in the SoC top, opposite its data port.

Parameters:
RAM_WORDS, 4096, RAM depth in 32-bit words (power of 2); RAM occupies 0x0000_0000..RAM_WORDS*4-1
MMIO_BASE, 32'h1000_0000, base of the MMIO page (64 B decoded, address[31:6] match)
FIFO_DEPTH, 8, console FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
address  in  32  byte address from processor; address[1:0] ignored
write_data  in  32  store data, already lane-aligned
wmask  in  4  byte-lane enables; bit i = write_data[8i+7:8i]
wen  in  1  store strobe, qualified by wmask
read_data  out  32  load data
con_valid  out  1  console FIFO non-empty
con_data  out  8  FIFO head byte
con_ready  in  1  sink accepts head byte
timer_irq  out  1  registered mtime >= mtimecmp
halt  out  1  sticky; set by tohost write
exit_code  out  32  value latched by tohost write

Behaviour:
- Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, FIFO empty, overflow=0, timer_irq=0, halt=0, exit_code=0. RAM contents are not reset.
- Store = wen && wmask!=0, committed at the rising edge. Load is combinational from address, zero latency; a same-cycle store does not affect read_data until the next cycle, so read-during-write returns old data.
- RAM: word index address[log2(RAM_WORDS)+1:2]; only lanes set in wmask are written. Addresses outside RAM and the MMIO page read 0, and stores there are ignored.
- MMIO offsets (address[5:2]):
  - 0x00 CON_TX: W pushes write_data[7:0] if wmask[0]=1 and the FIFO is not full. If full, the byte is dropped and overflow is set. R returns 0.
  - 0x04 CON_STAT: R = {29'b0, overflow, empty, full}. W with wmask[0]=1 and write_data[2]=1 clears overflow.
  - 0x08 / 0x0C MTIME_LO / MTIME_HI, R/W, byte-masked.
  - 0x10 / 0x14 MTIMECMP_LO / MTIMECMP_HI, R/W, byte-masked.
  - 0x18 TOHOST: any store sets halt=1 and exit_code=write_data. Further stores are ignored while halt=1. R returns exit_code.
- mtime increments by 1 every cycle and wraps from 2^64-1 to 0. In a cycle with a store to MTIME_LO/HI, written lanes take write_data, unwritten lanes of the full 64-bit value hold, and there is no increment that cycle.
- timer_irq is registered from the unsigned 64-bit compare (mtime >= mtimecmp) of the current values, so it is 1 cycle behind.
- Console FIFO:
  - con_valid = !empty; con_data = head.
  - Pop when con_valid && con_ready.
  - Full is evaluated before the same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs that cycle.
  - Push and pop on a non-full, non-empty FIFO both occur in the same cycle; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- halt does not stop the timer or the FIFO drain.
- Reset asserted mid-operation clears all state on that edge, including a same-cycle store or pop.

Test Plan:
- RAM byte masks: store 0xAABBCCDD to 0x40 with wmask=4'hF, then 0x11223344 with wmask=4'b0101 -> read 0x40 = 0xAA22CC44. A read in the store cycle returns the prior value.
- Unmapped access: store to 0x2000_0000, then read it -> 0, no state change. Read 0x1000_003C -> 0.
- Timer: after reset with no MMIO writes, read MTIME_LO at cycle N -> N. Write MTIMECMP_HI=0 and MTIMECMP_LO=20 -> timer_irq rises exactly one cycle after mtime reaches 20. Write MTIME_LO=0xFFFFFFFF and MTIME_HI=0 -> next cycle HI=1, LO=0 (carry).
- FIFO full/overflow: con_ready=0, push 9 bytes 0x41..0x49 -> CON_STAT=0b101, bytes 0x41..0x48 retained. Push to full with con_ready=1 -> dropped. Clear overflow by writing 4 to CON_STAT -> bit2=0.
- Drain and simultaneity: with 3 entries, push while popping every cycle -> count stays 3 and bytes come out in order. Toggle con_ready randomly -> no loss or duplication.
- Halt and reset: store 0x0000_0001 to TOHOST -> halt=1, exit_code=1. A second store of 5 -> exit_code stays 1. Assert reset for 1 cycle mid-drain -> halt=0, FIFO empty, mtime=0, timer_irq=0.
